// File: rtl/proc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// proc_ctrl_pkg
// Shared definitions for the processor run controller:
//   - PC_W                   : width of PC and data-memory words
//   - DEFAULT_*              : default parameter values for the controller
//   - state_t                : run-controller FSM states
//   - sat_inc8()             : 8-bit saturating increment for run statistics
// -----------------------------------------------------------------------------
package proc_ctrl_pkg;

   localparam int          PC_W                  = 64;
   localparam int          DEFAULT_RESET_CYCLES  = 1;
   localparam int          DEFAULT_SETTLE_CYCLES = 1;
   localparam logic [15:0] DEFAULT_WATCHDOG_MAX  = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_DONE    = 3'd4,
      ST_TIMEOUT = 3'd5
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/proc_run_controller_watchdog.sv
// -----------------------------------------------------------------------------
// run_watchdog
// Counts RUN cycles for the run controller and flags the watchdog limit.
// Ports:
//   CLK     in   clock
//   Reset   in   synchronous active-high reset
//   clear   in   zero the count (new run accepted)
//   enable  in   count this cycle (FSM is in RUN)
//   count   out  16-bit saturating cycle count
//   expired out  count has reached WATCHDOG_MAX-1, i.e. this is the last
//                RUN cycle allowed before a timeout
// -----------------------------------------------------------------------------
module run_watchdog
   import proc_ctrl_pkg::*;
#(
   parameter logic [15:0] WATCHDOG_MAX = DEFAULT_WATCHDOG_MAX
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        clear,
   input  logic        enable,
   output logic [15:0] count,
   output logic        expired
);

   logic [15:0] r_count;

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge value of its neighbours.
   always_ff @(posedge CLK) begin
      if (Reset || clear) begin
         r_count <= '0;
      end else if (enable && (r_count != 16'hFFFF)) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign count   = r_count;
   assign expired = (r_count == WATCHDOG_MAX - 16'd1);

endmodule

// File: rtl/proc_run_controller.sv
// -----------------------------------------------------------------------------
// proc_run_controller
// Sequences one processor test run: holds the processor in reset while the
// start PC is loaded, releases it, waits for the PC to pass the end address
// (or for the watchdog to expire), lets the data path settle, then samples
// and scores dMemOut against the expected value.
// Ports:
//   CLK, Reset      clock, synchronous active-high reset
//   start           run request pulse (honoured in IDLE/DONE/TIMEOUT only)
//   prog_start_pc   PC to load into the processor
//   prog_end_pc     run ends once currentPC >= this (unsigned)
//   expected        required dMemOut value
//   currentPC       processor PC
//   dMemOut         processor data-memory output
//   proc_Reset_L    active-low processor reset (high in RUN/SETTLE)
//   startPC         latched start PC driven to the processor
//   busy            LOAD, RUN or SETTLE
//   done            result valid (DONE or TIMEOUT)
//   pass            last result matched expected
//   timeout         last run hit the watchdog
//   result          captured dMemOut
//   pass_count      passed runs (saturating)
//   run_count       completed runs, including timeouts (saturating)
//   cycle_count     RUN cycles of the last or current run
// -----------------------------------------------------------------------------
module proc_run_controller
   import proc_ctrl_pkg::*;
#(
   parameter int          RESET_CYCLES  = DEFAULT_RESET_CYCLES,
   parameter int          SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
   parameter logic [15:0] WATCHDOG_MAX  = DEFAULT_WATCHDOG_MAX
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic            start,
   input  logic [PC_W-1:0] prog_start_pc,
   input  logic [PC_W-1:0] prog_end_pc,
   input  logic [PC_W-1:0] expected,
   input  logic [PC_W-1:0] currentPC,
   input  logic [PC_W-1:0] dMemOut,
   output logic            proc_Reset_L,
   output logic [PC_W-1:0] startPC,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic            timeout,
   output logic [PC_W-1:0] result,
   output logic [7:0]      pass_count,
   output logic [7:0]      run_count,
   output logic [15:0]     cycle_count
);

   state_t          r_state;
   state_t          w_next_state;

   logic [15:0]     r_phase;       // cycles spent in the current LOAD/SETTLE
   logic [PC_W-1:0] r_start_pc;
   logic [PC_W-1:0] r_end_pc;
   logic [PC_W-1:0] r_expected;
   logic [PC_W-1:0] r_result;
   logic            r_pass;
   logic [7:0]      r_run_count;
   logic [7:0]      r_pass_count;

   logic            w_accept;
   logic            w_run;
   logic            w_settle_last;
   logic            w_enter_timeout;
   logic            w_pc_reached;
   logic            w_load_last;
   logic            w_settle_end;
   logic            w_expired;
   logic            w_match;

   // Both operands are unsigned logic vectors, so this is an unsigned compare.
   assign w_pc_reached = (currentPC >= r_end_pc);
   assign w_load_last  = (r_phase == 16'(RESET_CYCLES - 1));
   assign w_settle_end = (r_phase == 16'(SETTLE_CYCLES - 1));
   assign w_match      = (dMemOut == r_expected);

   run_watchdog #(
      .WATCHDOG_MAX (WATCHDOG_MAX)
   ) u_watchdog (
      .CLK     (CLK),
      .Reset   (Reset),
      .clear   (w_accept),
      .enable  (w_run),
      .count   (cycle_count),
      .expired (w_expired)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      // NOTE: every output of this block is given a default first so no path
      // through the case statement can leave one unassigned and infer a latch.
      w_next_state    = r_state;
      w_accept        = 1'b0;
      w_run           = 1'b0;
      w_settle_last   = 1'b0;
      w_enter_timeout = 1'b0;
      busy            = 1'b0;
      proc_Reset_L    = 1'b0;
      done            = 1'b0;
      timeout         = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            busy = 1'b1;
            if (w_load_last) begin
               w_next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            busy         = 1'b1;
            proc_Reset_L = 1'b1;
            w_run        = 1'b1;
            // The end-PC compare takes priority over the watchdog limit.
            if (w_pc_reached) begin
               w_next_state = ST_SETTLE;
            end else if (w_expired) begin
               w_enter_timeout = 1'b1;
               w_next_state    = ST_TIMEOUT;
            end
         end
         ST_SETTLE: begin
            busy         = 1'b1;
            proc_Reset_L = 1'b1;
            if (w_settle_end) begin
               w_settle_last = 1'b1;
               w_next_state  = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = ST_LOAD;
            end
         end
         ST_TIMEOUT: begin
            done    = 1'b1;
            timeout = 1'b1;
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = ST_LOAD;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Run parameters, phase timer, result capture and statistics.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_phase      <= '0;
         r_start_pc   <= '0;
         r_end_pc     <= '0;
         r_expected   <= '0;
         r_result     <= '0;
         r_pass       <= 1'b0;
         r_run_count  <= '0;
         r_pass_count <= '0;
      end else begin
         // The phase timer restarts on every state change, so LOAD and
         // SETTLE each see it counting up from zero.
         if (w_next_state != r_state) begin
            r_phase <= '0;
         end else if ((r_state == ST_LOAD) || (r_state == ST_SETTLE)) begin
            r_phase <= r_phase + 16'd1;
         end

         if (w_accept) begin
            r_start_pc <= prog_start_pc;
            r_end_pc   <= prog_end_pc;
            r_expected <= expected;
            r_pass     <= 1'b0;
         end

         if (w_settle_last) begin
            r_result    <= dMemOut;
            r_pass      <= w_match;
            r_run_count <= sat_inc8(r_run_count);
            if (w_match) begin
               r_pass_count <= sat_inc8(r_pass_count);
            end
         end

         // A timeout counts as a completed (failed) run; result is kept.
         if (w_enter_timeout) begin
            r_pass      <= 1'b0;
            r_run_count <= sat_inc8(r_run_count);
         end
      end
   end

   assign startPC    = r_start_pc;
   assign result     = r_result;
   assign pass       = r_pass;
   assign run_count  = r_run_count;
   assign pass_count = r_pass_count;

endmodule

// File: tb/tb_proc_run_controller.sv
// -----------------------------------------------------------------------------
// tb_proc_run_controller
// Directed bench for proc_run_controller. u_main uses default parameters and
// is driven by a processor model whose PC advances by 4 per RUN cycle.
// u_hang uses WATCHDOG_MAX=16, RESET_CYCLES=3, SETTLE_CYCLES=2 and sees a
// bench-controlled PC that stays frozen unless a step moves it.
// -----------------------------------------------------------------------------
module tb_proc_run_controller;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic        start_h = 1'b0;
   logic [63:0] prog_start_pc = '0;
   logic [63:0] prog_end_pc = '0;
   logic [63:0] expected = '0;
   logic [63:0] dmem = '0;
   logic [63:0] model_pc = '0;
   logic [63:0] h_pc = 64'h8;
   logic [63:0] h_dmem = '0;

   logic        m_prl, m_busy, m_done, m_pass, m_timeout;
   logic [63:0] m_start_pc, m_result;
   logic [7:0]  m_pass_count, m_run_count;
   logic [15:0] m_cycle_count;

   logic        h_prl, h_busy, h_done, h_pass, h_timeout;
   logic [63:0] h_start_pc, h_result;
   logic [7:0]  h_pass_count, h_run_count;
   logic [15:0] h_cycle_count;

   int n_pass   = 0;
   int n_fail   = 0;
   int n_checks = 0;

   always #5 CLK = ~CLK;

   // Processor model: loads startPC while held in reset, then steps by 4.
   always @(posedge CLK) begin
      model_pc <= m_prl ? model_pc + 64'd4 : m_start_pc;
   end

   proc_run_controller u_main (
      .CLK           (CLK),
      .Reset         (Reset),
      .start         (start),
      .prog_start_pc (prog_start_pc),
      .prog_end_pc   (prog_end_pc),
      .expected      (expected),
      .currentPC     (model_pc),
      .dMemOut       (dmem),
      .proc_Reset_L  (m_prl),
      .startPC       (m_start_pc),
      .busy          (m_busy),
      .done          (m_done),
      .pass          (m_pass),
      .timeout       (m_timeout),
      .result        (m_result),
      .pass_count    (m_pass_count),
      .run_count     (m_run_count),
      .cycle_count   (m_cycle_count)
   );

   proc_run_controller #(
      .RESET_CYCLES  (3),
      .SETTLE_CYCLES (2),
      .WATCHDOG_MAX  (16'd16)
   ) u_hang (
      .CLK           (CLK),
      .Reset         (Reset),
      .start         (start_h),
      .prog_start_pc (prog_start_pc),
      .prog_end_pc   (prog_end_pc),
      .expected      (expected),
      .currentPC     (h_pc),
      .dMemOut       (h_dmem),
      .proc_Reset_L  (h_prl),
      .startPC       (h_start_pc),
      .busy          (h_busy),
      .done          (h_done),
      .pass          (h_pass),
      .timeout       (h_timeout),
      .result        (h_result),
      .pass_count    (h_pass_count),
      .run_count     (h_run_count),
      .cycle_count   (h_cycle_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for done on the selected instance; n = negedges waited.
   task automatic wait_done(input bit hang, input int max, output int n);
      n = 0;
      while (((hang ? h_done : m_done) !== 1'b1) && (n < max)) begin
         @(negedge CLK);
         n++;
      end
   endtask

   initial begin
      int n;

      // ---------------- reset state
      repeat (3) @(negedge CLK);
      check("rst_flags", 64'({m_busy, m_done, m_pass, m_timeout, m_prl}), 64'd0);
      check("rst_counts", 64'({m_run_count, m_pass_count, m_cycle_count}), 64'd0);
      check("rst_startpc", m_start_pc, 64'd0);
      check("rst_result", m_result, 64'd0);
      Reset = 1'b0;

      // ---------------- normal pass: 17 RUN cycles, then 1 SETTLE
      prog_start_pc = 64'h0;  prog_end_pc = 64'h40;
      expected      = 64'hF;  dmem        = 64'hF;
      start = 1'b1; @(negedge CLK); start = 1'b0;
      check("t1_load_busy_prl", 64'({m_busy, m_prl}), 64'b10);
      @(negedge CLK);
      check("t1_run_busy_prl", 64'({m_busy, m_prl}), 64'b11);
      wait_done(1'b0, 40, n);
      check("t1_latency", 64'(n), 64'd18);
      check("t1_cycles", 64'(m_cycle_count), 64'd17);
      check("t1_flags_dn_ps_to_bz_prl", 64'({m_done, m_pass, m_timeout, m_busy, m_prl}), 64'b11000);
      check("t1_result", m_result, 64'hF);
      check("t1_run_pass_cnt", 64'({m_run_count, m_pass_count}), 64'h0101);

      // ---------------- mismatch: same run, dMemOut=0xE
      dmem = 64'hE;
      start = 1'b1; @(negedge CLK); start = 1'b0;
      check("t2_cleared_dn_ps_to", 64'({m_done, m_pass, m_timeout}), 64'd0);
      check("t2_cycles_cleared", 64'(m_cycle_count), 64'd0);
      @(negedge CLK);
      wait_done(1'b0, 40, n);
      check("t2_latency", 64'(n), 64'd18);
      check("t2_pass", 64'(m_pass), 64'd0);
      check("t2_result", m_result, 64'hE);
      check("t2_run_pass_cnt", 64'({m_run_count, m_pass_count}), 64'h0201);

      // ---------------- hang: PC frozen at 0x8, watchdog of 16
      prog_end_pc = 64'h40; h_pc = 64'h8; h_dmem = 64'h55;
      start_h = 1'b1; @(negedge CLK); start_h = 1'b0;
      check("t3_load1_busy_prl", 64'({h_busy, h_prl}), 64'b10);
      repeat (2) @(negedge CLK);
      check("t3_load3_busy_prl", 64'({h_busy, h_prl}), 64'b10);
      @(negedge CLK);
      check("t3_run_busy_prl", 64'({h_busy, h_prl}), 64'b11);
      wait_done(1'b1, 40, n);
      check("t3_latency", 64'(n), 64'd16);
      check("t3_cycles", 64'(h_cycle_count), 64'd16);
      check("t3_flags_dn_ps_to_bz_prl", 64'({h_done, h_pass, h_timeout, h_busy, h_prl}), 64'b10100);
      check("t3_result_kept", h_result, 64'd0);
      check("t3_run_pass_cnt", 64'({h_run_count, h_pass_count}), 64'h0100);

      // ---------------- PC reached on the watchdog-limit cycle: PC wins
      start_h = 1'b1; @(negedge CLK); start_h = 1'b0;
      repeat (3) @(negedge CLK);
      repeat (15) @(negedge CLK);
      check("t4_cycles_at_limit", 64'(h_cycle_count), 64'd15);
      h_pc = 64'h40;
      @(negedge CLK);
      check("t4_settle_busy_to", 64'({h_busy, h_timeout}), 64'b10);
      check("t4_cycles", 64'(h_cycle_count), 64'd16);
      @(negedge CLK);
      check("t4_settle2_busy_dn", 64'({h_busy, h_done}), 64'b10);
      @(negedge CLK);
      check("t4_done_dn_to_bz", 64'({h_done, h_timeout, h_busy}), 64'b100);
      check("t4_result", h_result, 64'h55);
      check("t4_run_pass_cnt", 64'({h_run_count, h_pass_count}), 64'h0200);

      // ---------------- mid-run reset
      prog_start_pc = 64'h100; prog_end_pc = 64'h200;
      expected      = 64'hF;   dmem        = 64'hF;
      start = 1'b1; @(negedge CLK); start = 1'b0;
      @(negedge CLK);
      repeat (5) @(negedge CLK);
      check("t5_run_cycles", 64'(m_cycle_count), 64'd5);
      check("t5_startpc", m_start_pc, 64'h100);
      Reset = 1'b1;
      @(negedge CLK);
      Reset = 1'b0;
      check("t5_rst_flags", 64'({m_busy, m_done, m_pass, m_timeout, m_prl}), 64'd0);
      check("t5_rst_counts", 64'({m_run_count, m_pass_count, m_cycle_count}), 64'd0);
      check("t5_rst_startpc", m_start_pc, 64'd0);
      check("t5_rst_result", m_result, 64'd0);
      check("t5_rst_hang_done", 64'({h_done, h_run_count}), 64'd0);

      // ---------------- run after reset, with a start pulse ignored in RUN
      prog_end_pc = 64'h140;
      start = 1'b1; @(negedge CLK); start = 1'b0;
      @(negedge CLK);
      repeat (3) @(negedge CLK);
      prog_start_pc = 64'h999;
      start = 1'b1; @(negedge CLK); start = 1'b0;
      check("t6_ignored_startpc", m_start_pc, 64'h100);
      check("t6_ignored_cycles", 64'(m_cycle_count), 64'd4);
      wait_done(1'b0, 40, n);
      check("t6_latency", 64'(n), 64'd14);
      check("t6_cycles", 64'(m_cycle_count), 64'd17);
      check("t6_run_pass_cnt", 64'({m_run_count, m_pass_count}), 64'h0101);

      // ---------------- start from DONE with end <= start: one RUN cycle
      prog_start_pc = 64'h10; prog_end_pc = 64'h0;
      start = 1'b1; @(negedge CLK); start = 1'b0;
      @(negedge CLK);
      check("t7_run_cycles", 64'(m_cycle_count), 64'd0);
      @(negedge CLK);
      check("t7_settle_bz_prl_dn", 64'({m_busy, m_prl, m_done}), 64'b110);
      check("t7_settle_cycles", 64'(m_cycle_count), 64'd1);
      @(negedge CLK);
      check("t7_done", 64'({m_done, m_pass, m_busy}), 64'b110);
      check("t7_run_pass_cnt", 64'({m_run_count, m_pass_count}), 64'h0202);
      check("t7_startpc", m_start_pc, 64'h10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/proc_run_controller.md
PROC_RUN_CONTROLLER -- requirements
Module: proc_run_controller

Interface
REQ-001 The block SHALL have parameter RESET_CYCLES, default 1: cycles for which the processor reset is held low before a run.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 1: cycles after the end PC is reached before the result is sampled.
REQ-003 The block SHALL have parameter WATCHDOG_MAX, default 16'hFFFF: RUN cycle limit before a timeout is declared.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; the clock port is CLK and the reset port is Reset.
REQ-005 Ports SHALL be:
- CLK  in  1  clock
- Reset  in  1  synchronous active-high reset
- start  in  1  run request pulse
- prog_start_pc  in  64  PC to load into the processor
- prog_end_pc  in  64  run terminates when currentPC >= this value
- expected  in  64  required dMemOut value
- currentPC  in  64  processor PC
- dMemOut  in  64  processor data-memory output
- proc_Reset_L  out  1  active-low processor reset
- startPC  out  64  processor start PC
- busy  out  1  run in progress
- done  out  1  result valid
- pass  out  1  last result matched
- timeout  out  1  last run hit the watchdog
- result  out  64  captured dMemOut
- pass_count  out  8  passed runs
- run_count  out  8  completed runs
- cycle_count  out  16  RUN cycles of the last or current run

Function
REQ-006 The FSM SHALL have states IDLE, LOAD, RUN, SETTLE, DONE and TIMEOUT.
REQ-007 In IDLE, DONE or TIMEOUT, start=1 SHALL latch prog_start_pc into startPC, latch prog_end_pc and expected, clear done, pass, timeout and cycle_count, and enter LOAD on the next edge.
REQ-008 start SHALL be ignored in LOAD, RUN and SETTLE.
REQ-009 LOAD SHALL last exactly RESET_CYCLES cycles, then enter RUN.
REQ-010 proc_Reset_L SHALL be decoded from the registered state:
- 0 in IDLE, LOAD, DONE and TIMEOUT;
- 1 in RUN and SETTLE.
REQ-011 In RUN, each cycle SHALL increment cycle_count, saturating at 16'hFFFF.
REQ-012 In RUN, the unsigned compare currentPC >= end_pc SHALL move the FSM to SETTLE.
REQ-013 In RUN, if the compare is false and cycle_count == WATCHDOG_MAX-1, the FSM SHALL move to TIMEOUT.
REQ-014 If the PC compare and the watchdog limit occur in the same cycle, the PC compare SHALL win.
REQ-015 SETTLE SHALL last exactly SETTLE_CYCLES cycles; on its last cycle:
- dMemOut is captured into result;
- pass = (dMemOut == expected);
- run_count and pass_count (if pass) increment, each saturating at 8'hFF;
- the FSM enters DONE.
REQ-016 On entering TIMEOUT:
- timeout=1, done=1, pass=0;
- run_count increments;
- result is unchanged.
REQ-017 busy SHALL be 1 exactly in LOAD, RUN and SETTLE.
REQ-018 done SHALL stay 1 from entry to DONE/TIMEOUT until the next accepted start or Reset.
REQ-019 If prog_end_pc <= prog_start_pc, the first RUN cycle SHALL exit to SETTLE (cycle_count=1).

Reset
REQ-020 Reset SHALL force IDLE in the same edge, from any state, including mid-run.
REQ-021 On Reset, all counters, startPC and result SHALL be cleared to 0.
REQ-022 On Reset, busy, done, pass and timeout SHALL be 0 and proc_Reset_L SHALL be 0.

Structure
REQ-023 Package proc_ctrl_pkg SHALL hold the state enum, the 64-bit PC/data width constant and the default parameter values.
REQ-024 The watchdog/cycle counter SHALL be a sub-module named run_watchdog, with ports clear, enable, count and expired.

Verification
REQ-025 Normal pass: processor model PC=start+4 per RUN cycle; start=0, end=0x40, expected=0xF, dMemOut=0xF -> cycle_count=17, pass=1, pass_count=1, done=1.
REQ-026 Mismatch: same run with dMemOut=0xE -> pass=0, result=0xE, run_count increments, pass_count unchanged.
REQ-027 Hang: model PC frozen at 0x8, WATCHDOG_MAX=16 -> timeout=1, done=1 after 16 RUN cycles, proc_Reset_L=0.
REQ-028 Mid-run reset: Reset for one cycle during RUN -> next cycle IDLE, all outputs 0, and a subsequent start runs normally.
REQ-029 Back-to-back runs: start pulsed in RUN is ignored; start in DONE with end=0x0 -> SETTLE after 1 RUN cycle, run_count=2.
